// File: rtl/seq_multiplier.sv
// Sequential 4x4 unsigned shift-and-add multiplier: one multiplier bit per clock,
// 8-bit ripple adder of full_adder cells, registered product with a one-cycle done strobe.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module seq_multiplier (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       start,
    output logic [7:0] product,
    output logic       busy,
    output logic       done
);
    localparam int unsigned OpW   = 4;
    localparam int unsigned ProdW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q;
    logic [ProdW-1:0]   mcand_q;
    logic [OpW-1:0]     mq_q;
    logic [ProdW-1:0]   acc_q;
    logic [1:0]         cnt_q;
    logic [ProdW-1:0]   product_q;

    logic [ProdW-1:0]   sum;
    logic [ProdW:0]     carry;
    logic [ProdW-1:0]   acc_d;
    logic               carry_out_unused;

    // acc + mcand through a ripple chain; 15*15 fits in 8 bits so the carry-out is dropped
    assign carry[0] = 1'b0;
    for (genvar i = 0; i < ProdW; i++) begin : g_adder
        full_adder u_fa (
            .a    (acc_q[i]),
            .b    (mcand_q[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end
    assign carry_out_unused = carry[ProdW];

    assign acc_d = mq_q[0] ? sum : acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mq_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        mcand_q <= {4'b0, A};
                        mq_q    <= B;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    mcand_q <= mcand_q << 1;
                    mq_q    <= mq_q >> 1;
                    cnt_q   <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        product_q <= acc_d;
                        state_q   <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign product = product_q;
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed vector table, multi-cycle corner
// sequences and randomized traffic against a cycle-level behavioural model.

module tb_seq_multiplier;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic       start;
    logic [7:0] product;
    logic       busy;
    logic       done;

    seq_multiplier dut (
        .clk     (clk),
        .rst     (rst),
        .A       (A),
        .B       (B),
        .start   (start),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int done_seen = 0;

    // Model: phase 0 = idle, 1..4 = running (phase-1 iterations done), 5 = done cycle
    int         m_phase = 0;
    logic [7:0] m_prod  = 8'h00;
    logic [7:0] m_pend  = 8'h00;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_phase = 0;
            m_prod  = 8'h00;
        end else if (m_phase == 0 || m_phase == 5) begin
            if (start) begin
                m_pend  = 8'(int'(A) * int'(B));
                m_phase = 1;
            end else begin
                m_phase = 0;
            end
        end else if (m_phase == 4) begin
            m_prod  = m_pend;
            m_phase = 5;
        end else begin
            m_phase = m_phase + 1;
        end
        #1;
        check("model_busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= 4));
        check("model_done", 32'(done), 32'(m_phase == 5));
        check("model_product", 32'(product), 32'(m_prod));
        if (done) done_seen++;
    endtask

    // Steps until done is seen (bounded); 99 means it never arrived
    task automatic wait_done(output int cycles);
        cycles = 99;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (done) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idle_after);
        int lat;
        A = v.a; B = v.b; start = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_capture", 32'(busy), 32'd1);
        wait_done(lat);
        check("latency", 32'(lat), 32'd4);
        check("vec_product", 32'(product), 32'(v.exp));
        for (int i = 0; i < idle_after; i++) begin
            step();
            check("product_hold", 32'(product), 32'(v.exp));
        end
    endtask

    vec_t vecs[6];

    initial begin
        int lat;
        int d0;
        vecs[0] = '{a: 4'hF, b: 4'hF, exp: 8'hE1};
        vecs[1] = '{a: 4'hA, b: 4'h3, exp: 8'h1E};
        vecs[2] = '{a: 4'h7, b: 4'h0, exp: 8'h00};
        vecs[3] = '{a: 4'h0, b: 4'h9, exp: 8'h00};
        vecs[4] = '{a: 4'h1, b: 4'h8, exp: 8'h08};
        vecs[5] = '{a: 4'hC, b: 4'hB, exp: 8'h84};

        rst = 1'b1; start = 1'b0; A = 4'h0; B = 4'h0;
        #1;
        check("reset_product", 32'(product), 32'h00);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Directed vectors, each followed by 10 idle cycles of product hold
        for (int i = 0; i < 6; i++) run_vec(vecs[i], 10);

        // start pulse during RUN is ignored
        d0 = done_seen;
        A = 4'h5; B = 4'h6; start = 1'b1;
        step();
        start = 1'b0;
        step();
        A = 4'hF; B = 4'hF; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("ignore_done_count", 32'(done_seen - d0), 32'd1);
        check("ignore_product", 32'(product), 32'h1E);

        // Back-to-back: restart from DONE with no bubble
        A = 4'h3; B = 4'h4; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(lat);
        check("b2b_first_product", 32'(product), 32'h0C);
        A = 4'h9; B = 4'h9; start = 1'b1;
        step();
        start = 1'b0;
        check("b2b_done_low", 32'(done), 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done(lat);
        check("b2b_spacing", 32'(lat + 1), 32'd5);
        check("b2b_second_product", 32'(product), 32'h51);
        step();

        // Held start restarts only from DONE
        d0 = done_seen;
        A = 4'h2; B = 4'h7; start = 1'b1;
        for (int i = 0; i < 12; i++) step();
        start = 1'b0;
        check("held_done_count", 32'(done_seen - d0), 32'd2);
        check("held_product", 32'(product), 32'h0E);
        for (int i = 0; i < 6; i++) step();

        // Reset mid-operation
        A = 4'hF; B = 4'hF; start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("midrst_product", 32'(product), 32'h00);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        step();
        rst = 1'b0;
        d0 = done_seen;
        for (int i = 0; i < 6; i++) step();
        check("midrst_no_done", 32'(done_seen - d0), 32'd0);
        run_vec('{a: 4'h2, b: 4'h3, exp: 8'h06}, 2);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            A = 4'($urandom);
            B = 4'($urandom);
            start = ($urandom_range(0, 3) == 0);
            step();
        end
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
